// File: rtl/seq_priority_encoder_pkg.sv
// Shared definitions for the sequential 16-to-4 priority encoder.
//   N, W          : request width and code width
//   ST_*          : FSM state encodings (2'd3 is unused and recovers to IDLE)
//   popcount16()  : number of set bits in a 16-bit vector, 0..16
package seq_priority_encoder_pkg;

    localparam int N = 16;
    localparam int W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_EMPTY = 2'd2;

    function automatic logic [W:0] popcount16(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-bit priority encoder, bit 0 has highest priority.
//   in_i     : input vector
//   idx_o    : index of the lowest set bit (0 when no bit is set)
//   any_o    : at least one bit set
//   single_o : exactly one bit set
module prio_enc16
    import seq_priority_encoder_pkg::*;
(
    input  logic [N-1:0] in_i,
    output logic [W-1:0] idx_o,
    output logic         any_o,
    output logic         single_o
);

    always_comb begin
        idx_o = '0;
        // Scan from the top down so the lowest set bit is the final writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (in_i[i]) idx_o = W'(i);
        end
    end

    assign any_o    = |in_i;
    // Clearing the lowest set bit leaves zero only when one bit was set.
    assign single_o = any_o && ((in_i & (in_i - 1'b1)) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// Sequential 16-to-4 encoder: latches a request vector, then emits the index
// of every set bit, lowest first, one valid/ready beat per bit. An all-zero
// vector produces a single beat flagged with none.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready/req : request vector handshake (ready only in IDLE)
//   code_valid/code_ready   : output beat handshake
//   code, last, none        : beat payload
//   busy                    : a vector is latched and not yet drained
//   count                   : popcount of the latched vector, present only
//                             when SEQ_PRIORITY_ENCODER_COUNT_EN is defined
// All outputs decode registered state only.
module seq_priority_encoder
    import seq_priority_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] code,
    output logic         last,
    output logic         none,
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    output logic [W:0]   count,
`endif
    output logic         busy
);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] idx;
    logic         any;
    logic         single;

    prio_enc16 u_enc (
        .in_i     (pend_q),
        .idx_o    (idx),
        .any_o    (any),
        .single_o (single)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pend_d  = req;
                    state_d = (req != '0) ? ST_EMIT : ST_EMPTY;
                end
            end
            ST_EMIT: begin
                if (code_ready) begin
                    // Drop the bit just emitted (the lowest set bit).
                    pend_d = pend_q & (pend_q - 1'b1);
                    if (single) state_d = ST_IDLE;
                end
            end
            ST_EMPTY: begin
                if (code_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign code_valid = (state_q == ST_EMIT) || (state_q == ST_EMPTY);
    assign busy       = code_valid;
    assign code       = (state_q == ST_EMIT) ? idx : '0;
    assign last       = ((state_q == ST_EMIT) && any && single) || (state_q == ST_EMPTY);
    assign none       = (state_q == ST_EMPTY);

`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    logic [W:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (req_valid && req_ready) begin
            count_q <= popcount16(req);
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder. Inputs change and outputs are
// sampled 1 time unit after the rising edge.
module tb_seq_priority_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req;
    logic        code_valid;
    logic        code_ready;
    logic [3:0]  code;
    logic        last;
    logic        none;
    logic        busy;
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    logic [4:0]  count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_priority_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req        (req),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .last       (last),
        .none       (none),
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
        .count      (count),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Full output snapshot: valid, code, last, none, ready, busy.
    task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                           input logic l, input logic n, input logic rr);
        chk({tag, ".valid"}, {15'b0, code_valid}, {15'b0, v});
        chk({tag, ".code"},  {12'b0, code},       {12'b0, c});
        chk({tag, ".last"},  {15'b0, last},       {15'b0, l});
        chk({tag, ".none"},  {15'b0, none},       {15'b0, n});
        chk({tag, ".ready"}, {15'b0, req_ready},  {15'b0, rr});
        chk({tag, ".busy"},  {15'b0, busy},       {15'b0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a vector for one edge (block is in IDLE), then withdraw it.
    task automatic accept(input logic [15:0] v);
        req       = v;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req       = 16'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req        = 16'h0;
        code_ready = 1'b1;
        #12;
        chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        #3 rst_n = 1'b1;
        step();
        chk_out("idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 0x0029 -> codes 0,3,5
        accept(16'h0029);
        chk_out("v29_b0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("v29_b1", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("v29_b2", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("v29_done", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // all-zero vector -> one empty beat
        accept(16'h0000);
        chk_out("v00_b0", 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
        chk("v00_count", {11'b0, count}, 16'd0);
`endif
        step();
        chk_out("v00_done", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 0x8001 with backpressure; a competing request must be ignored
        code_ready = 1'b0;
        accept(16'h8001);
        req_valid = 1'b1;
        req       = 16'h0004;
        chk_out("v8001_h0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("v8001_h1", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("v8001_h2", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        req_valid  = 1'b0;
        code_ready = 1'b1;
        step();
        chk_out("v8001_b1", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
        // Back-to-back: offer the next vector as the last beat is taken.
        req_valid = 1'b1;
        req       = 16'h8000;
        step();
        chk_out("b2b_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        req_valid = 1'b0;
        req       = 16'h0;
        chk_out("v8000_b0", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("v8000_done", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        // 0xFFFF -> 16 beats, last only on 15
        accept(16'hFFFF);
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
        chk("vffff_count", {11'b0, count}, 16'd16);
`endif
        for (int i = 0; i < 16; i++) begin
            chk_out($sformatf("vffff_b%0d", i), 1'b1, 4'(i), (i == 15), 1'b0, 1'b0);
            step();
        end
        chk_out("vffff_done", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
        chk("vffff_count_hold", {11'b0, count}, 16'd16);
`endif

        // Reset mid-vector, asserted between edges
        accept(16'hFFFF);
        for (int i = 0; i < 4; i++) step();
        chk_out("mid_b4", 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("mid_pend", dut.pend_q, 16'h0);
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
        chk("mid_count", {11'b0, count}, 16'd0);
`endif
        step();
        chk_out("mid_hold", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        accept(16'h0002);
        chk_out("v02_b0", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("v02_done", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
